sensor_enable_driver: RTL and testbench
=======================================

Name: sensor_enable_driver

Overview:
- Initiator side of the sensor-select interface: the sensor selector returns the one enable line chosen by a 5-bit address; this block drives that enable bus.
- On a start request it latches the 5-bit sensor address and drives the 32-bit enable bus one-hot.
- It then waits for the addressed sensor's acknowledge, or gives up after a timeout.
- It reports completion with a one-cycle done pulse and a status flag. It sits between the measurement controller and the 32-sensor array.

Parameters:
TIMEOUT_CYCLES, 1024, maximum number of cycles enable is held waiting for ack (legal range 2..65535)
CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES
RETRIES, 2, extra attempts after a timeout (used only with the optional feature)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous active-low reset
start  input  1  request pulse/level; sampled only in IDLE
endS  input  5  sensor address; latched on the edge that accepts start
ack  input  1  acknowledge from the addressed sensor (the selector output)
enable  output  32  one-hot sensor enable bus, registered
busy  output  1  high from accept until the cycle after done
done  output  1  one-cycle completion pulse
timeout  output  1  status: 1 = last transaction timed out, 0 = acked; valid from done until next accept
addr_q  output  5  latched address of the current or last transaction

Behaviour:
- Reset (rst=0, asynchronous): enable=0, busy=0, done=0, timeout=0, addr_q=0, counter=0, state=IDLE. This applies immediately, including mid-transaction.
- States: IDLE, DRIVE, FINISH. All outputs are registered.
- IDLE:
  - enable=0, busy=0.
  - If start=1 at an edge: addr_q<=endS, enable<=(1<<endS), busy<=1, counter<=0, timeout<=0, go to DRIVE.
  - Enable is therefore visible in the cycle after the accepting edge.
- DRIVE:
  - Enable is held at exactly one bit set; endS changes are ignored (addr_q is used).
  - ack is sampled from the first edge in DRIVE onward.
  - If ack=1: enable<=0, done<=1, timeout<=0, go to FINISH.
  - Else if counter==TIMEOUT_CYCLES-1: enable<=0, done<=1, timeout<=1, go to FINISH.
  - Else counter<=counter+1.
  - Without ack, enable is high for exactly TIMEOUT_CYCLES cycles.
- Simultaneous ack and final timeout count: ack wins, timeout=0.
- FINISH:
  - done<=0, busy<=0, go to IDLE.
  - start during FINISH is ignored. A new accept is possible at the earliest on the edge after FINISH, so back-to-back transactions are separated by one idle cycle.
- start while busy: ignored, with no queueing.
- ack while in IDLE or FINISH: ignored.
- Counter does not wrap: it saturates at TIMEOUT_CYCLES-1, and this is never reached beyond the transition.
- enable is never multi-hot. It is all-zero in every state except DRIVE.

Optional Feature:
- Macro SENSOR_RETRY_EN.
- Defined:
  - A retry counter (reset 0 on accept) is added.
  - On timeout in DRIVE with retries < RETRIES: enable<=0 for one cycle (state RELEASE), then re-enter DRIVE with counter<=0, same addr_q, retries+1. done is not pulsed.
  - timeout=1 with done only after RETRIES+1 failed attempts.
  - ack during any attempt completes normally.
- Not defined: no RELEASE state and no retry counter; the first timeout ends the transaction.

Test Plan:
- Reset mid-DRIVE (endS=7, enable=0x00000080): drop rst -> enable=0, busy=0, state IDLE immediately, without waiting for a clock edge.
- start=1, endS=5'd3; ack=1 four cycles after enable rises -> enable=0x00000008 for exactly 4 cycles, done pulse 1 cycle, timeout=0, addr_q=3.
- start, endS=5'd31, ack held 0, TIMEOUT_CYCLES=16 -> enable=0x80000000 for exactly 16 cycles, then done=1 and timeout=1. With SENSOR_RETRY_EN and RETRIES=2: three 16-cycle enable windows separated by 1-cycle gaps, one done.
- ack=1 on the same cycle counter reaches TIMEOUT_CYCLES-1 -> done=1, timeout=0.
- start held high, endS changed 3->9 during DRIVE -> enable stays 0x00000008; the second accept happens one cycle after FINISH with addr_q=9.

Source files
------------

// File: rtl/sensor_enable_driver_if.sv
// Sensor-select bus between the measurement controller, the enable driver and
// the sensor array. The driver uses the slave modport.
interface sensor_enable_driver_if;
    logic        start;
    logic [4:0]  endS;
    logic        ack;
    logic [31:0] enable;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [4:0]  addr_q;

    modport master (output start, endS, ack,
                    input  enable, busy, done, timeout, addr_q);
    modport slave  (input  start, endS, ack,
                    output enable, busy, done, timeout, addr_q);
endinterface

// File: rtl/sensor_enable_driver.sv
// One-hot sensor enable driver: latch address, hold enable until ack or timeout.
// Optional retry-after-timeout support is compiled in with SENSOR_RETRY_EN.
module sensor_enable_driver #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16,
    parameter int RETRIES        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sensor_enable_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, FINISH, RELEASE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] enable_q, enable_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic [4:0]  addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        last_cnt;

    assign last_cnt = (cnt_q == CNT_LAST);

`ifdef SENSOR_RETRY_EN
    localparam int RTRY_W = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
    logic [RTRY_W-1:0] rtry_q, rtry_d;
    logic              rtry_left;
    assign rtry_left = (rtry_q < RTRY_W'(RETRIES));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            enable_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
`ifdef SENSOR_RETRY_EN
            rtry_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
`ifdef SENSOR_RETRY_EN
            rtry_q    <= rtry_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = DRIVE;
            DRIVE: begin
                if (bus.ack) state_d = FINISH;
                else if (last_cnt) begin
`ifdef SENSOR_RETRY_EN
                    state_d = rtry_left ? RELEASE : FINISH;
`else
                    state_d = FINISH;
`endif
                end
            end
            FINISH:  state_d = IDLE;
            RELEASE: state_d = DRIVE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        enable_d  = enable_q;
        busy_d    = busy_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
`ifdef SENSOR_RETRY_EN
        rtry_d    = rtry_q;
`endif
        case (state_q)
            IDLE: begin
                enable_d = '0;
                busy_d   = 1'b0;
                if (bus.start) begin
                    addr_d    = bus.endS;
                    enable_d  = 32'd1 << bus.endS;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
`ifdef SENSOR_RETRY_EN
                    rtry_d    = '0;
`endif
                end
            end
            DRIVE: begin
                // ack is checked before the count so a coincident ack wins
                if (bus.ack) begin
                    enable_d  = '0;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                end else if (last_cnt) begin
                    enable_d = '0;
`ifdef SENSOR_RETRY_EN
                    if (rtry_left) begin
                        rtry_d = rtry_q + 1'b1;
                    end else begin
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
`else
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINISH: begin
                done_d = 1'b0;
                busy_d = 1'b0;
            end
            RELEASE: begin
                enable_d = 32'd1 << addr_q;
                cnt_d    = '0;
            end
            default: enable_d = '0;
        endcase
    end

    always_comb begin
        bus.enable  = enable_q;
        bus.busy    = busy_q;
        bus.done    = done_q;
        bus.timeout = timeout_q;
        bus.addr_q  = addr_q;
    end
endmodule

// File: tb/tb_sensor_enable_driver.sv
// Directed bench for sensor_enable_driver with TIMEOUT_CYCLES=16, RETRIES=2.
module tb_sensor_enable_driver;
    localparam int TO = 16;
    localparam int RT = 2;
`ifdef SENSOR_RETRY_EN
    localparam int WINDOWS = RT + 1;
`else
    localparam int WINDOWS = 1;
`endif

    logic clk;
    logic rst;
    int   ntests;
    int   nfail;

    sensor_enable_driver_if bus ();

    sensor_enable_driver #(.TIMEOUT_CYCLES(TO), .CNT_W(16), .RETRIES(RT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one transaction; ack is raised so the DUT samples it after ack_at
    // enable-high cycles of the current window (0 = never acknowledge).
    task automatic run_txn(input logic [4:0] a, input int ack_at,
                           output int en_cyc, output int win, output int dn,
                           output logic to, output logic oh_ok);
        logic prev;
        en_cyc = 0; win = 0; dn = 0; to = 1'bx; oh_ok = 1'b1; prev = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.endS  = a;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.enable != 32'd0) begin
                en_cyc++;
                if (!prev) win++;
                if (bus.enable !== (32'd1 << a)) oh_ok = 1'b0;
            end
            prev = (bus.enable != 32'd0);
            if (bus.done === 1'b1) begin
                dn++;
                to = bus.timeout;
            end
            if (dn > 0 && bus.done === 1'b0 && bus.busy === 1'b0) break;
            bus.ack = (ack_at > 0) && (bus.enable != 32'd0) && (en_cyc == ack_at);
            @(negedge clk);
        end
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        ntests++;
        if (bus.enable !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.timeout !== 1'b0 || bus.addr_q !== 5'd0) begin
            nfail++;
            $display("FAIL reset_state: enable=%h busy=%b done=%b timeout=%b addr=%0d required all zero",
                     bus.enable, bus.busy, bus.done, bus.timeout, bus.addr_q);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ack();
        int en, w, dn; logic to, oh;
        run_txn(5'd3, 4, en, w, dn, to, oh);
        ntests++;
        if (en !== 4) begin nfail++; $display("FAIL ack_en_cycles: got %0d required 4", en); end
        ntests++;
        if (dn !== 1 || to !== 1'b0) begin
            nfail++; $display("FAIL ack_done: done_pulses=%0d timeout=%b required 1/0", dn, to);
        end
        ntests++;
        if (!oh || bus.addr_q !== 5'd3) begin
            nfail++; $display("FAIL ack_onehot_addr: onehot_ok=%b addr=%0d required 1/3", oh, bus.addr_q);
        end
    endtask

    task automatic test_timeout();
        int en, w, dn; logic to, oh;
        run_txn(5'd31, 0, en, w, dn, to, oh);
        ntests++;
        if (en !== TO * WINDOWS || w !== WINDOWS) begin
            nfail++; $display("FAIL timeout_windows: cycles=%0d windows=%0d required %0d/%0d",
                              en, w, TO * WINDOWS, WINDOWS);
        end
        ntests++;
        if (dn !== 1 || to !== 1'b1) begin
            nfail++; $display("FAIL timeout_done: done_pulses=%0d timeout=%b required 1/1", dn, to);
        end
        ntests++;
        if (!oh) begin nfail++; $display("FAIL timeout_onehot: enable was not 0x80000000"); end
        @(negedge clk);
        ntests++;
        if (bus.timeout !== 1'b1 || bus.addr_q !== 5'd31) begin
            nfail++; $display("FAIL timeout_hold: timeout=%b addr=%0d required 1/31", bus.timeout, bus.addr_q);
        end
    endtask

    task automatic test_ack_at_last();
        int en, w, dn; logic to, oh;
        run_txn(5'd12, TO, en, w, dn, to, oh);
        ntests++;
        if (en !== TO || dn !== 1 || to !== 1'b0) begin
            nfail++; $display("FAIL ack_last_count: cycles=%0d done=%0d timeout=%b required %0d/1/0",
                              en, dn, to, TO);
        end
    endtask

    task automatic test_idle_ack();
        logic bad;
        bad = 1'b0;
        bus.ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.enable !== 32'd0 || bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
        end
        bus.ack = 1'b0;
        ntests++;
        if (bad) begin
            nfail++; $display("FAIL idle_ack: enable=%h done=%b busy=%b required idle outputs",
                              bus.enable, bus.done, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.endS  = 5'd3;
        @(negedge clk);
        bus.endS = 5'd9;
        if (bus.enable !== 32'h8) bad = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.enable !== 32'h8) bad = 1'b1;
        end
        ntests++;
        if (bad) begin nfail++; $display("FAIL b2b_hold: enable=%h required 00000008", bus.enable); end
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        ntests++;
        if (bus.done !== 1'b1 || bus.enable !== 32'd0 || bus.busy !== 1'b1) begin
            nfail++; $display("FAIL b2b_finish: done=%b enable=%h busy=%b required 1/0/1",
                              bus.done, bus.enable, bus.busy);
        end
        @(negedge clk);
        ntests++;
        if (bus.busy !== 1'b0 || bus.enable !== 32'd0 || bus.done !== 1'b0) begin
            nfail++; $display("FAIL b2b_gap: busy=%b enable=%h done=%b required 0/0/0",
                              bus.busy, bus.enable, bus.done);
        end
        @(negedge clk);
        bus.start = 1'b0;
        ntests++;
        if (bus.enable !== 32'h200 || bus.addr_q !== 5'd9 || bus.busy !== 1'b1) begin
            nfail++; $display("FAIL b2b_second: enable=%h addr=%0d busy=%b required 00000200/9/1",
                              bus.enable, bus.addr_q, bus.busy);
        end
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.start = 1'b1;
        bus.endS  = 5'd7;
        @(negedge clk);
        bus.start = 1'b0;
        ntests++;
        if (bus.enable !== 32'h80 || bus.busy !== 1'b1) begin
            nfail++; $display("FAIL rst_mid_pre: enable=%h busy=%b required 00000080/1", bus.enable, bus.busy);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        ntests++;
        if (bus.enable !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.addr_q !== 5'd0) begin
            nfail++; $display("FAIL rst_mid_async: enable=%h busy=%b done=%b addr=%0d required zeros",
                              bus.enable, bus.busy, bus.done, bus.addr_q);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        ntests++;
        if (bus.enable !== 32'd0 || bus.busy !== 1'b0) begin
            nfail++; $display("FAIL rst_mid_idle: enable=%h busy=%b required 0/0", bus.enable, bus.busy);
        end
    endtask

    initial begin
        ntests    = 0;
        nfail     = 0;
        bus.start = 1'b0;
        bus.endS  = 5'd0;
        bus.ack   = 1'b0;
        test_reset();
        test_ack();
        test_timeout();
        test_ack_at_last();
        test_idle_ack();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
